bl_sample_stream_fifo: RTL and testbench

- Sits directly downstream of the Bendlab I2C control path; consumes the assembled 32-bit sample register and its update strobe.
- Timestamps each completed sample and buffers it in a record FIFO.
- Serialises each record as two 32-bit words to a host-side read port (pipe-out style).
- Reports fill level, overflow drops and underflow reads for debug and LEDs.

---
 rtl/bl_sample_stream_fifo.sv | 142 ++++++++++++++
 tb/tb_bl_sample_stream_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bl_sample_stream_fifo.sv
// rtl/bl_sample_stream_fifo.sv - timestamped sample record FIFO with two-word host read serialiser
module bl_sample_stream_fifo #(
    parameter int          FIFO_ADDR_WIDTH = 4,
    parameter logic [7:0]  SYNC_BYTE       = 8'hB1,
    parameter int          DATA_IN_WIDTH   = 32,
    // Timestamp value loaded on reset; 0 in normal use
    parameter logic [31:0] TS_INIT         = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DATA_IN_WIDTH-1:0]   sample_in,
    input  logic                       sample_stb,
    input  logic                       rd_en,
    output logic [31:0]                dout,
    output logic                       dout_valid,
    output logic [FIFO_ADDR_WIDTH+1:0] words_avail,
    output logic                       overflow,
    output logic [15:0]                drop_cnt,
    output logic                       underflow,
    input  logic                       clr_flags
);

    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [31:0]   ts;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   rec_count;
    logic          phase;

    logic [23:0]   mem_data [DEPTH];
    logic [31:0]   mem_ts   [DEPTH];

    logic          full;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          rd_ok;
    logic          rd_empty;
    logic          pop;
    logic          phase_nxt;
    logic [AW:0]   rec_count_nxt;
    logic [AW+1:0] words_nxt;
    logic [31:0]   head_word;

    // Upper sample bits carry no payload
    logic unused_sample_bits;
    assign unused_sample_bits = &{1'b0, sample_in[DATA_IN_WIDTH-1:24]};

    // Push/pop decisions all use the state as it stood before this edge
    always_comb begin
        full          = (rec_count == FULL_COUNT);
        push_req      = sample_stb & enable;
        push          = push_req & ~full;
        drop          = push_req & full;
        rd_empty      = (words_avail == '0);
        rd_ok         = rd_en & ~rd_empty;
        pop           = rd_ok & phase;
        phase_nxt     = phase ^ rd_ok;
        rec_count_nxt = rec_count;
        if (push && !pop) begin
            rec_count_nxt = rec_count + 1'b1;
        end else if (!push && pop) begin
            rec_count_nxt = rec_count - 1'b1;
        end
        words_nxt     = {rec_count_nxt, 1'b0} - {{(AW+1){1'b0}}, phase_nxt};
        head_word     = phase ? mem_ts[rd_ptr] : {SYNC_BYTE, mem_data[rd_ptr]};
    end

    // Record storage, written on accepted pushes, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sample_in[23:0];
            mem_ts[wr_ptr]   <= ts;
        end
    end

    // Timestamp, pointers, occupancy and read phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts          <= TS_INIT;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rec_count   <= '0;
            phase       <= 1'b0;
            words_avail <= '0;
        end else begin
            ts          <= ts + 32'd1;
            rec_count   <= rec_count_nxt;
            phase       <= phase_nxt;
            words_avail <= words_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Read data register: loads only on a successful read, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
            if (rd_ok) begin
                dout <= head_word;
            end
        end
    end

    // Sticky debug flags and drop counter; a new event beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (rd_en && rd_empty) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
            if (clr_flags) begin
                drop_cnt <= drop ? 16'd1 : 16'd0;
            end else if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bl_sample_stream_fifo.sv
// tb/tb_bl_sample_stream_fifo.sv - randomized and directed checks against a queue-based record model
module tb_bl_sample_stream_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] sample_in;
    logic        sample_stb;
    logic        rd_en;
    logic        clr_flags;
    logic [31:0] dout;
    logic        dout_valid;
    logic [5:0]  words_avail;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        underflow;

    logic        w_rst_n;
    logic        w_enable;
    logic [31:0] w_sample_in;
    logic        w_sample_stb;
    logic        w_rd_en;
    logic        w_clr_flags;
    logic [31:0] w_dout;
    logic        w_dout_valid;
    logic [5:0]  w_words_avail;
    logic        w_overflow;
    logic [15:0] w_drop_cnt;
    logic        w_underflow;

    always #5 clk = ~clk;

    bl_sample_stream_fifo dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
        .sample_stb(sample_stb), .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
        .words_avail(words_avail), .overflow(overflow), .drop_cnt(drop_cnt),
        .underflow(underflow), .clr_flags(clr_flags)
    );

    bl_sample_stream_fifo #(.TS_INIT(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .enable(w_enable), .sample_in(w_sample_in),
        .sample_stb(w_sample_stb), .rd_en(w_rd_en), .dout(w_dout), .dout_valid(w_dout_valid),
        .words_avail(w_words_avail), .overflow(w_overflow), .drop_cnt(w_drop_cnt),
        .underflow(w_underflow), .clr_flags(w_clr_flags)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of {data[23:0], ts[31:0]} records plus read phase
    logic [55:0] q[$];
    bit          m_phase;
    bit          m_ovf;
    bit          m_udf;
    int          m_drop;
    logic [31:0] m_dout;
    bit          m_valid;
    logic [31:0] m_ts;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_avail();
        return 2 * q.size() - int'(m_phase);
    endfunction

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_ovf   = 0;
        m_udf   = 0;
        m_drop  = 0;
        m_dout  = '0;
        m_valid = 0;
        m_ts    = '0;
    endtask

    task automatic model_step();
        bit          full_pre;
        bit          drop;
        bit          udf;
        logic [55:0] head;
        full_pre = (q.size() == 16);
        drop     = 0;
        udf      = 0;
        m_valid  = 0;
        if (rd_en) begin
            if (m_avail() > 0) begin
                head    = q[0];
                m_dout  = m_phase ? head[31:0] : {8'hB1, head[55:32]};
                m_valid = 1;
                if (m_phase) void'(q.pop_front());
                m_phase = !m_phase;
            end else begin
                udf = 1;
            end
        end
        if (sample_stb && enable) begin
            if (!full_pre) q.push_back({sample_in[23:0], m_ts});
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr_flags) m_ovf = 0;
        if (udf) m_udf = 1;
        else if (clr_flags) m_udf = 0;
        if (clr_flags) m_drop = drop ? 1 : 0;
        else if (drop && m_drop < 65535) m_drop++;
        m_ts = m_ts + 32'd1;
    endtask

    // One clock: model step on pre-edge inputs, then compare outputs #1 after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_valid});
        chk("dout", dout, m_dout);
        chk("words_avail", {26'd0, words_avail}, 32'(m_avail()));
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_udf});
        chk("drop_cnt", {16'd0, drop_cnt}, 32'(m_drop));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sample_stb = 0;
        rd_en      = 0;
        clr_flags  = 0;
        enable     = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        chk("async_rst_words", {26'd0, words_avail}, 32'd0);
        chk("async_rst_dout", dout, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_flags", {29'd0, overflow, underflow, |drop_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    logic [31:0] smp [4];
    int          drop_before;

    initial begin
        rst_n = 0; idle_inputs(); sample_in = '0;
        w_rst_n = 0; w_enable = 1; w_sample_in = '0; w_sample_stb = 0; w_rd_en = 0; w_clr_flags = 0;
        @(negedge clk);
        do_reset();

        // 1: single sample at ts=100, two reads
        for (int i = 0; i < 200 && m_ts != 32'd100; i++) tick();
        sample_in = 32'h0012_3456; sample_stb = 1; tick(); sample_stb = 0;
        chk("t1_avail2", {26'd0, words_avail}, 32'd2);
        rd_en = 1; tick();
        chk("t1_word0", dout, 32'hB112_3456);
        chk("t1_avail1", {26'd0, words_avail}, 32'd1);
        tick(); rd_en = 0;
        chk("t1_word1", dout, 32'd100);
        chk("t1_avail0", {26'd0, words_avail}, 32'd0);
        tick();
        chk("t1_valid_low", {31'd0, dout_valid}, 32'd0);

        // 2: fill past capacity, then drain all 32 words
        for (int i = 0; i < 18; i++) begin
            sample_in = $urandom; sample_stb = 1; tick();
        end
        sample_stb = 0; tick();
        chk("t2_avail32", {26'd0, words_avail}, 32'd32);
        chk("t2_overflow", {31'd0, overflow}, 32'd1);
        chk("t2_drop2", {16'd0, drop_cnt}, 32'd2);
        rd_en = 1;
        for (int i = 0; i < 32; i++) tick();
        rd_en = 0; tick();

        // 3: full FIFO, push rejected while a phase-1 read frees a record
        for (int i = 0; i < 16; i++) begin
            sample_in = $urandom; sample_stb = 1; tick();
        end
        sample_stb = 0;
        rd_en = 1; tick();
        drop_before = int'(drop_cnt);
        sample_in = $urandom; sample_stb = 1; tick();
        sample_stb = 0; rd_en = 0;
        chk("t3_avail30", {26'd0, words_avail}, 32'd30);
        chk("t3_drop_inc", {16'd0, drop_cnt}, 32'(drop_before + 1));

        // 4: drain, read empty, then clear flags
        rd_en = 1;
        for (int i = 0; i < 40 && m_avail() > 0; i++) tick();
        rd_en = 0; tick();
        rd_en = 1; tick(); rd_en = 0;
        chk("t4_underflow", {31'd0, underflow}, 32'd1);
        chk("t4_valid0", {31'd0, dout_valid}, 32'd0);
        clr_flags = 1; tick(); clr_flags = 0;
        chk("t4_clr", {29'd0, overflow, underflow, |drop_cnt}, 32'd0);

        // 5: reset with a half-read record
        sample_in = $urandom; sample_stb = 1; tick(); sample_stb = 0;
        rd_en = 1; tick(); rd_en = 0;
        do_reset();
        sample_in = 32'h00AB_CDEF; sample_stb = 1; tick(); sample_stb = 0;
        chk("t5_avail2", {26'd0, words_avail}, 32'd2);
        rd_en = 1; tick(); rd_en = 0;
        chk("t5_word0", dout, 32'hB1AB_CDEF);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            sample_in  = $urandom;
            sample_stb = ($urandom_range(2) == 0);
            enable     = ($urandom_range(7) != 0);
            rd_en      = ($urandom_range(1) == 1);
            clr_flags  = ($urandom_range(39) == 0);
            tick();
        end
        idle_inputs();
        tick();

        // 6: timestamp wrap on the second instance (reset value FFFFFFFC)
        for (int i = 0; i < 4; i++) smp[i] = $urandom;
        w_rst_n = 0; tick();
        w_rst_n = 1; tick(); tick();
        for (int i = 0; i < 3; i++) begin
            w_sample_in = smp[i]; w_sample_stb = 1; tick();
        end
        w_enable = 0; w_sample_in = smp[3]; tick();
        w_sample_stb = 0; w_enable = 1; tick();
        chk("t6_avail6", {26'd0, w_words_avail}, 32'd6);
        chk("t6_drop0", {16'd0, w_drop_cnt}, 32'd0);
        w_rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_word0", w_dout, {8'hB1, smp[i][23:0]});
            tick();
            chk("t6_ts", w_dout, 32'hFFFF_FFFE + 32'(i));
        end
        w_rd_en = 0; tick();
        chk("t6_empty", {26'd0, w_words_avail}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
